// File: rtl/freq_meter_bcd.sv
// Frequency meter: counts synchronized rising edges of sig_in over a gate window
// of N ckht cycles and publishes the count as saturating packed BCD.
module freq_meter_bcd #(
    parameter int N      = 50000000,
    parameter int DIGITS = 4
) (
    input  logic                  ckht,
    input  logic                  rst,
    input  logic                  sig_in,
    output logic [4*DIGITS-1:0]   freq_bcd,
    output logic                  ovf,
    output logic                  done,
    output logic                  valid
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] GATE_LAST = CW'(N - 1);

    typedef enum logic {
        FLUSH,
        MEASURE
    } state_t;

    state_t state, state_nxt;
    logic   flush_cnt;

    logic s1, s2, s3;
    logic rise;

    logic [CW-1:0]       gate;
    logic [4*DIGITS-1:0] live, live_inc, live_nxt;
    logic                ovf_live, ovf_live_nxt;
    logic                all_nines;
    logic                gate_en, count_en, close;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge ckht or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all three flops sample the
            // pre-edge values, so the chain really is three stages deep.
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge ckht or posedge rst) begin
        if (rst) begin
            state     <= FLUSH;
            flush_cnt <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FLUSH) begin
                flush_cnt <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        state_nxt = state;
        gate_en   = 1'b0;
        case (state)
            FLUSH: begin
                if (flush_cnt) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                gate_en = 1'b1;
            end
            default: state_nxt = FLUSH;
        endcase
    end

    assign close    = gate_en && (gate == GATE_LAST);
    assign count_en = gate_en & rise;

    // BCD ripple increment and all-nines detection for saturation.
    always_comb begin
        logic carry;
        live_inc  = live;
        all_nines = 1'b1;
        carry     = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (live[4*d +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (live[4*d +: 4] == 4'd9) begin
                    live_inc[4*d +: 4] = 4'd0;
                end else begin
                    live_inc[4*d +: 4] = live[4*d +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
    end

    assign live_nxt     = (count_en && !all_nines) ? live_inc : live;
    assign ovf_live_nxt = ovf_live | (count_en & all_nines);

    always_ff @(posedge ckht or posedge rst) begin
        if (rst) begin
            gate     <= '0;
            live     <= '0;
            ovf_live <= 1'b0;
            freq_bcd <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            if (!gate_en || close) begin
                gate <= '0;
            end else begin
                gate <= gate + CW'(1);
            end

            // The closing cycle's own edge belongs to the window being published.
            if (close) begin
                freq_bcd <= live_nxt;
                ovf      <= ovf_live_nxt;
                done     <= 1'b1;
                valid    <= 1'b1;
                live     <= '0;
                ovf_live <= 1'b0;
            end else begin
                done     <= 1'b0;
                live     <= live_nxt;
                ovf_live <= ovf_live_nxt;
            end
        end
    end

endmodule

// File: doc/freq_meter_bcd.md
Name: freq_meter_bcd

Overview:
- Measures the frequency of an external digital signal by counting its rising edges over a fixed gate window of N ckht cycles.
- At the default N, at 50 MHz, the window is 1 s, so the result is in Hz.
- The result is published as packed BCD for the 7-segment display path, with a done strobe and an overflow flag.
- It is the measuring counterpart of the enable-pulse divider: it consumes a pulse train and reports its rate.

Parameters:
- N, 50000000, ckht cycles per gate window (≥4).
- DIGITS, 4, number of BCD digits in the result (1..8).

Ports:
- ckht  in  1  system clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sig_in  in  1  signal under measurement; asynchronous to ckht.
- freq_bcd  out  4*DIGITS  last completed window's edge count, packed BCD, digit 0 in bits [3:0].
- ovf  out  1  last completed window exceeded the maximum BCD value (all digits 9).
- done  out  1  one-cycle pulse when freq_bcd/ovf update.
- valid  out  1  high once at least one window has completed since reset.

Behaviour:
- Reset (async, rst=1): freq_bcd=0, ovf=0, done=0, valid=0. Synchronizer flops, edge history, gate counter and live BCD count all clear. FSM enters FLUSH.
- Synchronizer: sig_in passes through two flops (s1, s2) plus a history flop s3. rise = s2 & ~s3. Edge-to-count latency is 3 ckht cycles.
- FSM states:
  - FLUSH: lasts 2 cycles after reset release, letting the synchronizer fill. rise is ignored; the gate counter is held at 0. Then go to MEASURE.
  - MEASURE: gate counter increments each cycle, 0..N-1, then wraps to 0. Stays in MEASURE until reset.
- Live count: in MEASURE, each cycle with rise=1 increments the live BCD count.
  - Digit increment rule: a digit at 9 goes to 0 and carries into the next digit; otherwise it adds 1.
  - Saturation: if all digits are 9 when rise=1, the count holds at all 9s and a per-window sticky ovf_live flag sets.
- Window close, on the cycle where the gate counter equals N-1:
  - freq_bcd is loaded with the live count including any rise in that same cycle, saturated as above.
  - ovf is loaded with ovf_live, also including that cycle's saturation.
  - done=1 for exactly this cycle; valid is set to 1 and stays set.
  - The live count and ovf_live clear to 0, so a rise in the next cycle counts as 1 in the new window.
- Between closes: freq_bcd and ovf hold; done=0.
- Width: the gate counter is ceil(log2(N)) bits. No binary-to-BCD conversion is used; counting is directly in BCD.
- Maximum measurable: 10^DIGITS − 1 edges per window. Input is reliable up to ckht/4 (at least 2 cycles high and 2 cycles low).
- Reset mid-window: the window is abandoned; outputs return to their reset values; the next window begins after FLUSH.
- sig_in stuck high or low: no edges, so the published value is 0 each window.
- No glitch filtering: a pulse shorter than one ckht period may or may not be counted.

Test Plan:
- Reset check, N=100, DIGITS=4: assert rst for 3 cycles with sig_in toggling → freq_bcd=16'h0000, ovf=0, done=0, valid=0. Release rst → first done exactly 102 cycles after release (2 FLUSH + 100 MEASURE).
- Basic rate, N=100: sig_in period 10 cycles (5 high, 5 low), steady → every window freq_bcd=16'h0010, ovf=0. done pulses once every 100 cycles; valid=1 after the first window.
- BCD carry, N=1000: sig_in period 4 cycles → freq_bcd=16'h0250; checks the digit 9→0 carry across digits 0 and 1.
- Saturation, N=100, DIGITS=1: sig_in period 4 cycles (25 edges) → freq_bcd=4'h9, ovf=1. Then sig_in held 0 for the next window → freq_bcd=4'h0, ovf=0.
- Boundary edge, N=100: inject exactly one rise whose synchronized rise lands on gate counter N-1 → that window reports 16'h0001 and the following window reports 16'h0000. Repeat with rise at counter 0 → it is counted in the new window only.
- Reset mid-window, N=100: steady 10-cycle input, assert rst at gate counter 50 → outputs clear immediately (async). After release, the next done comes 102 cycles later with 16'h0010.
